// File: rtl/d_ff_rstn_if.sv
// Data bundle for the d_ff_rstn state element.
// Carries the captured input and both output polarities.
interface d_ff_rstn_if #(
   parameter int unsigned WIDTH = 1
);
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_not;

   modport master (
      output d,
      input  q,
      input  q_not
   );

   modport slave (
      input  d,
      output q,
      output q_not
   );
endinterface

// File: rtl/d_ff_rstn.sv
// Rising-edge D flip-flop, async active-low reset.
// Drives q and its bitwise complement q_not.
module d_ff_rstn #(
   parameter int unsigned          WIDTH       = 1,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic        clk,
   input  logic        reset_n,
   d_ff_rstn_if.slave  bus
);

   logic [WIDTH-1:0] state;

   // capture d on each rising edge; reset forces RESET_VALUE at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RESET_VALUE;
      end else begin
         state <= bus.d;
      end
   end

   assign bus.q     = state;
   assign bus.q_not = ~state;

endmodule

// File: tb/tb_d_ff_rstn.sv
// Randomized self-checking bench for d_ff_rstn.
// Exercises 1-bit and 8-bit instances against a timeline model.
`timescale 1ns/1ps
module tb_d_ff_rstn;

   logic clk;
   logic reset_n;

   d_ff_rstn_if #(.WIDTH(1)) bus1 ();
   d_ff_rstn_if #(.WIDTH(8)) bus8 ();

   d_ff_rstn #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0)
   ) u_dff1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   d_ff_rstn #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dff8 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus8)
   );

   // 1 us period, 50% duty
   initial clk = 1'b0;
   always #500 clk = ~clk;

   int   total;
   int   passed;
   logic       exp1;
   logic [7:0] exp8;

   task automatic check(input string tag,
                        input logic [7:0] obs,
                        input logic [7:0] exp);
      total++;
      if (obs === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: observed %h required %h @%0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      logic nexp1;
      nexp1 = ~exp1;
      check({tag, ".q1"},    {7'b0, bus1.q},     {7'b0, exp1});
      check({tag, ".qn1"},   {7'b0, bus1.q_not}, {7'b0, nexp1});
      check({tag, ".q8"},    bus8.q,             exp8);
      check({tag, ".qn8"},   bus8.q_not,         ~exp8);
   endtask

   // watchdog: the run is a few tens of microseconds
   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      total   = 0;
      passed  = 0;
      reset_n = 1'b1;
      bus1.d  = 1'b0;
      bus8.d  = 8'h00;

      // reset entry: outputs forced without a clock edge
      #10 reset_n = 1'b0;
      exp1 = 1'b0;
      exp8 = 8'hA5;
      #1 check_all("reset_entry");

      // reset hold: d toggles across several edges
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         n = $urandom_range(1, 4);
         repeat (n) begin
            @(posedge clk);
            #1 check_all("reset_hold_edge");
         end
         #($urandom_range(100, 400));
         bus1.d = ~bus1.d;
         bus8.d = 8'($urandom);
         #1 check_all("reset_hold_d");
      end

      // release mid-cycle with d = 1 held
      @(negedge clk);
      bus1.d = 1'b1;
      bus8.d = 8'h3C;
      #100 reset_n = 1'b1;
      #1 check_all("release_hold");
      @(posedge clk);
      exp1 = 1'b1;
      exp8 = 8'h3C;
      #1 check_all("release_capture");

      // normal capture with random d between edges
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #($urandom_range(10, 400));
         bus1.d = ~bus1.d;
         bus8.d = 8'($urandom);
         #1 check_all("between_edges");
         n = $urandom_range(1, 4);
         repeat (n) begin
            @(posedge clk);
            exp1 = bus1.d;
            exp8 = bus8.d;
            #1 check_all("capture");
            #400 check_all("hold");
         end
      end

      // mid-cycle asynchronous reset with q = 1
      @(negedge clk);
      bus1.d = 1'b1;
      bus8.d = 8'hFF;
      @(posedge clk);
      exp1 = 1'b1;
      exp8 = 8'hFF;
      #1 check_all("pre_reset");
      #199 reset_n = 1'b0;
      exp1 = 1'b0;
      exp8 = 8'hA5;
      #1 check_all("async_reset");
      repeat (2) begin
         @(posedge clk);
         #1 check_all("reset_dominates");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
